// File: rtl/i2s_sample_output.sv
// i2s_sample_output
//   Buffers the mono sample stream from the synth core in a small FIFO and
//   serialises each sample over Philips I2S. The same sample is sent in the
//   left and right slots. BCLK is a divided i_Clock and a frame is 32 BCLK
//   periods, so the DAC side runs independently of when samples arrive.
//
// Ports
//   i_Clock        system clock
//   i_Reset        synchronous, active-high reset
//   i_SampleReady  one-cycle push strobe qualifying i_Sample
//   i_Sample       16-bit signed PCM sample
//   i_ClearFlags   clears the sticky over/underflow flags
//   o_I2S_BCLK     bit clock, i_Clock / (2*BCLK_DIV)
//   o_I2S_LRCLK    word select (0 = left, 1 = right)
//   o_I2S_SDATA    serial data, MSB first, one BCLK after each LRCLK edge
//   o_FifoLevel    current FIFO occupancy
//   o_Overflow     sticky: a pushed sample was dropped because the FIFO was full
//   o_Underflow    sticky: a frame started while the FIFO was empty
module i2s_sample_output #(
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_SampleReady,
  input  logic [15:0]                   i_Sample,
  input  logic                          i_ClearFlags,
  output logic                          o_I2S_BCLK,
  output logic                          o_I2S_LRCLK,
  output logic                          o_I2S_SDATA,
  output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
  output logic                          o_Overflow,
  output logic                          o_Underflow
);

  localparam int unsigned DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SMP_W  = 16;
  localparam int unsigned SHR_W  = 2 * SMP_W;
  localparam int unsigned BIT_W  = 5;

  // State registers
  logic [DIV_W-1:0] div_q,    div_d;
  logic             bclk_q,   bclk_d;
  logic [BIT_W-1:0] bit_q,    bit_d;
  logic [SHR_W-1:0] shift_q,  shift_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;

  logic [SMP_W-1:0] mem [FIFO_DEPTH];

  // Event / handshake decode
  logic             div_tc;
  logic             fall_evt;
  logic             load_evt;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop_ok;
  logic             push_ok;
  logic [SMP_W-1:0] load_word;

  // Event decode and FIFO push/pop arbitration
  always_comb begin
    div_tc     = (div_q == DIV_W'(BCLK_DIV - 1));
    fall_evt   = div_tc && bclk_q;
    // The fall event that takes the bit counter 0 -> 1 starts a new word
    load_evt   = fall_evt && (bit_q == '0);
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    pop_ok     = load_evt && !fifo_empty;
    // A full FIFO still accepts a push when a pop frees the slot this cycle
    push_ok    = i_SampleReady && (!fifo_full || pop_ok);
    load_word  = pop_ok ? mem[rd_ptr_q] : '0;
  end

  // Next-state logic
  always_comb begin
    div_d    = div_q;
    bclk_d   = bclk_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (div_tc) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end

    if (fall_evt) begin
      bit_d = bit_q + BIT_W'(1);
      if (load_evt) begin
        shift_d = {load_word, load_word};
      end else begin
        shift_d = {shift_q[SHR_W-2:0], 1'b0};
      end
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);

    // Sticky flags: clear first so a coincident set wins
    if (i_ClearFlags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (i_SampleReady && !push_ok) begin
      ovf_d = 1'b1;
    end
    if (load_evt && fifo_empty) begin
      unf_d = 1'b1;
    end
  end

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Sample storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && push_ok) begin
      mem[wr_ptr_q] <= i_Sample;
    end
  end

  // All outputs come straight from flops
  assign o_I2S_BCLK  = bclk_q;
  assign o_I2S_LRCLK = bit_q[BIT_W-1];
  assign o_I2S_SDATA = shift_q[SHR_W-1];
  assign o_FifoLevel = level_q;
  assign o_Overflow  = ovf_q;
  assign o_Underflow = unf_q;

endmodule

// File: tb/tb_i2s_sample_output.sv
// tb_i2s_sample_output
//   Directed bench for i2s_sample_output at BCLK_DIV=4, FIFO_DEPTH=8.
//   cyc counts rising edges since reset release; outputs are sampled on the
//   falling edge after edge number cyc.
module tb_i2s_sample_output;

  logic        i_Clock;
  logic        i_Reset;
  logic        i_SampleReady;
  logic [15:0] i_Sample;
  logic        i_ClearFlags;
  logic        o_I2S_BCLK;
  logic        o_I2S_LRCLK;
  logic        o_I2S_SDATA;
  logic [3:0]  o_FifoLevel;
  logic        o_Overflow;
  logic        o_Underflow;

  i2s_sample_output #(
    .BCLK_DIV   (4),
    .FIFO_DEPTH (8)
  ) dut (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_SampleReady (i_SampleReady),
    .i_Sample      (i_Sample),
    .i_ClearFlags  (i_ClearFlags),
    .o_I2S_BCLK    (o_I2S_BCLK),
    .o_I2S_LRCLK   (o_I2S_LRCLK),
    .o_I2S_SDATA   (o_I2S_SDATA),
    .o_FifoLevel   (o_FifoLevel),
    .o_Overflow    (o_Overflow),
    .o_Underflow   (o_Underflow)
  );

  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  typedef struct {
    int   cyc;
    logic bclk;
    logic lrclk;
    logic sdata;
    int   level;
    logic ovf;
    logic unf;
  } vec_t;

  int   checks;
  int   failures;
  int   cyc;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clock);
    cyc++;
    @(negedge i_Clock);
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk_all(input string tag, input logic bclk, input logic lrclk, input logic sdata,
                         input int level, input logic ovf, input logic unf);
    chk({tag, "_bclk"},  32'(o_I2S_BCLK),  32'(bclk));
    chk({tag, "_lrclk"}, 32'(o_I2S_LRCLK), 32'(lrclk));
    chk({tag, "_sdata"}, 32'(o_I2S_SDATA), 32'(sdata));
    chk({tag, "_level"}, 32'(o_FifoLevel), 32'(level));
    chk({tag, "_ovf"},   32'(o_Overflow),  32'(ovf));
    chk({tag, "_unf"},   32'(o_Underflow), 32'(unf));
  endtask

  task automatic do_reset(input string tag);
    i_Reset       = 1'b1;
    i_SampleReady = 1'b0;
    i_ClearFlags  = 1'b0;
    step();
    step();
    chk_all(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    i_Reset = 1'b0;
    cyc     = 0;
  endtask

  // Collect the 16 left-slot bits (periods 1..16) and 16 right-slot bits
  // (periods 17..31 plus period 0 of the next frame) of frame f.
  task automatic capture(input int f, output logic [15:0] l, output logic [15:0] r);
    l = '0;
    r = '0;
    for (int p = 1; p <= 32; p++) begin
      step_to(256 * f + 8 * p + 4);
      if (p <= 16) l = {l[14:0], o_I2S_SDATA};
      else         r = {r[14:0], o_I2S_SDATA};
    end
  endtask

  initial begin
    logic [15:0] lw;
    logic [15:0] rw;
    logic [15:0] exp_w;

    checks        = 0;
    failures      = 0;
    cyc           = 0;
    i_Reset       = 1'b1;
    i_SampleReady = 1'b0;
    i_Sample      = '0;
    i_ClearFlags  = 1'b0;

    // Expected waveform after pushing 0x8001 on edge 1
    //        cyc  bclk lr  sd  lvl ovf unf
    vecs.push_back('{  1, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{  4, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{  7, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{  8, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{ 12, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{ 16, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{124, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{127, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{128, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{132, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{140, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{148, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{252, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{255, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{256, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{260, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{263, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{264, 0, 0, 0, 0, 0, 1});

    @(negedge i_Clock);

    // Reset state, single sample, then empty-FIFO underflow
    do_reset("rst1");
    i_SampleReady = 1'b1;
    i_Sample      = 16'h8001;
    step();
    i_SampleReady = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      step_to(vecs[i].cyc);
      chk_all($sformatf("v%0d", i), vecs[i].bclk, vecs[i].lrclk, vecs[i].sdata,
              vecs[i].level, vecs[i].ovf, vecs[i].unf);
    end

    // Underflow frame carries silence in both slots
    capture(1, lw, rw);
    chk("unf_frame_left",  32'(lw), 32'h0);
    chk("unf_frame_right", 32'(rw), 32'h0);

    // Clear, then set-dominant clear on the load edge
    i_ClearFlags = 1'b1;
    step();
    i_ClearFlags = 1'b0;
    chk("clear_unf", 32'(o_Underflow), 32'h0);
    step_to(519);
    i_ClearFlags = 1'b1;
    step();
    i_ClearFlags = 1'b0;
    chk("set_dominant_unf", 32'(o_Underflow), 32'h1);
    step();
    chk("unf_sticky", 32'(o_Underflow), 32'h1);
    i_ClearFlags = 1'b1;
    step();
    i_ClearFlags = 1'b0;
    chk("clear_unf2", 32'(o_Underflow), 32'h0);

    // Overflow on the ninth push, then push while full on a load edge
    do_reset("rst2");
    step_to(8);
    chk("t4_unf_first", 32'(o_Underflow), 32'h1);
    for (int k = 1; k <= 9; k++) begin
      i_SampleReady = 1'b1;
      i_Sample      = 16'(k);
      step();
      if (k == 8) begin
        chk("t4_level_full", 32'(o_FifoLevel), 32'd8);
        chk("t4_no_ovf_yet", 32'(o_Overflow),  32'h0);
      end
    end
    i_SampleReady = 1'b0;
    chk("t4_level_sat", 32'(o_FifoLevel), 32'd8);
    chk("t4_ovf",       32'(o_Overflow),  32'h1);
    i_ClearFlags = 1'b1;
    step();
    i_ClearFlags = 1'b0;
    chk("t4_clr_ovf", 32'(o_Overflow),  32'h0);
    chk("t4_clr_unf", 32'(o_Underflow), 32'h0);
    step_to(263);
    i_SampleReady = 1'b1;
    i_Sample      = 16'h0BEE;
    step();
    i_SampleReady = 1'b0;
    chk("t5_level_kept", 32'(o_FifoLevel), 32'd8);
    chk("t5_no_ovf",     32'(o_Overflow),  32'h0);
    for (int f = 1; f <= 10; f++) begin
      if (f <= 8)       exp_w = 16'(f);
      else if (f == 9)  exp_w = 16'h0BEE;
      else              exp_w = 16'h0000;
      capture(f, lw, rw);
      chk($sformatf("frame%0d_left", f),  32'(lw), 32'(exp_w));
      chk($sformatf("frame%0d_right", f), 32'(rw), 32'(exp_w));
    end
    chk("t5_level_end", 32'(o_FifoLevel), 32'd0);
    chk("t5_unf_end",   32'(o_Underflow), 32'h1);
    chk("t5_ovf_end",   32'(o_Overflow),  32'h0);

    // Reset mid-frame with bit counter 20 and three samples queued
    do_reset("rst3");
    step_to(8);
    for (int k = 1; k <= 3; k++) begin
      i_SampleReady = 1'b1;
      i_Sample      = 16'(k * 16'h1111);
      step();
    end
    i_SampleReady = 1'b0;
    step_to(164);
    chk("t6_pre_level", 32'(o_FifoLevel), 32'd3);
    chk("t6_pre_lrclk", 32'(o_I2S_LRCLK), 32'h1);
    chk("t6_pre_bclk",  32'(o_I2S_BCLK),  32'h1);
    chk("t6_pre_unf",   32'(o_Underflow), 32'h1);
    i_Reset = 1'b1;
    step();
    chk_all("t6_mid_rst", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    i_Reset = 1'b0;
    cyc     = 0;
    step_to(4);
    chk("t6_bclk_rise",  32'(o_I2S_BCLK),  32'h1);
    chk("t6_p0_sdata",   32'(o_I2S_SDATA), 32'h0);
    step_to(8);
    chk("t6_bclk_fall",  32'(o_I2S_BCLK),  32'h0);
    chk("t6_load_level", 32'(o_FifoLevel), 32'd0);
    chk("t6_load_unf",   32'(o_Underflow), 32'h1);
    chk("t6_load_sdata", 32'(o_I2S_SDATA), 32'h0);
    step_to(127);
    chk("t6_lrclk_low",  32'(o_I2S_LRCLK), 32'h0);
    step_to(128);
    chk("t6_lrclk_high", 32'(o_I2S_LRCLK), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
